door_code_sender: RTL and testbench
===================================

# door_code_sender

Initiator for the button-sequence door lock. It holds a programmable 5-symbol code and, on `start`, resets the lock, drives the code onto the lock's `btn` inputs one symbol per clock, then captures the lock's pass/fail result. It sits between the board-level controller/testbench and the lock, and serves both as an auto-unlock source and as a self-test driver.

## Interface
Parameters:
- `N_SYM`, 5 — symbols per frame; must match the lock's frame length.
- `RESULT_WAIT`, 4 — maximum WAIT cycles before declaring timeout (≥1).
- `DEFAULT_CODE`, 10'b10_00_01_00_10 — code register reset value, 2 bits per symbol, sym0 in [1:0]; decodes to the sequence 2,0,1,0,2.

Ports:
- `clk` in 1 — the single clock.
- `reset` in 1 — asynchronous, active-low.
- `code_ld` in 1 — load `code_in` into the code register (accepted in IDLE only).
- `code_in` in 2*N_SYM — new code; symbol k is in [2k+1:2k].
- `start` in 1 — begin a frame (accepted in IDLE only).
- `ld_in` in 2 — lock result; [1] = pass (lock ld5), [0] = fail (lock ld4).
- `btn_out` out 3 — one-hot button drive to the lock.
- `lock_rst` out 1 — active-high reset to the lock.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse when a frame completes.
- `pass`, `fail`, `timeout` out 1 each — sticky result flags, at most one high.

## Operation
- Symbol decode: 00→btn 001, 01→010, 10→100, 11→000 (no press; deliberately sends a wrong digit).
- FSM states:
  - IDLE→RST on `start`.
  - RST: `lock_rst`=1 for 1 cycle, then →SEND.
  - SEND: N_SYM cycles, with index k = 0..N_SYM-1 and `btn_out` = decode(sym k); after k = N_SYM-1 →WAIT.
  - WAIT: `btn_out`=0.
    - If `ld_in`=2'b10, set `pass` and →DONE.
    - Else if `ld_in`=2'b01, set `fail` and →DONE.
    - Otherwise, after RESULT_WAIT cycles, set `timeout` and →DONE.
    - `ld_in`=2'b11 is illegal and treated as fail.
  - DONE: `done`=1 for 1 cycle, then →IDLE.
- Accepting `start` clears `pass`, `fail` and `timeout` at the same edge.
- `start` and `code_ld` while busy are ignored. The code register is frozen during a frame.
- `code_ld` and `start` in the same IDLE cycle: the new code loads, and that frame sends the new code.
- Index counter is $clog2(N_SYM) bits and resets to 0 on entry to SEND. Wait counter is $clog2(RESULT_WAIT+1) bits.

## Timing
- All outputs are registered except `lock_rst`, which is `state==RST` OR `reset` low (combinational), so the lock is held in reset while this block is in reset.
- Reset values:
  - state IDLE.
  - `btn_out`=0, `busy`=0, `done`=0.
  - `pass`=`fail`=`timeout`=0.
  - `lock_rst`=1 (reset asserted).
  - code register = DEFAULT_CODE.
- Cycle numbering, with `start` sampled at the edge ending cycle 0:
  - cycle 1: `lock_rst`=1, `busy`=1.
  - cycles 2..6: sym0..sym4 on `btn_out`; the lock samples each symbol at that cycle's closing edge.
  - cycle 7: first WAIT cycle; the lock result is valid on `ld_in`.
  - cycle 8: `done`=1 with the flag set (start-to-done = 8 cycles).
- Timeout path: `done` in cycle 7+RESULT_WAIT.
- Reset asserted mid-frame: immediate return to IDLE, `btn_out`=0, flags cleared, code register reloads DEFAULT_CODE.

## Structure
- Package `door_code_pkg`:
  - FSM state enum (IDLE, RST, SEND, WAIT, DONE).
  - Symbol encodings SYM_0, SYM_1, SYM_2, SYM_NONE.
  - One-hot button constants.
  - DEFAULT_CODE.
- Sub-module `code_sym_decode`: combinational 2-bit symbol to 3-bit one-hot, instantiated once on the selected symbol.
- Top level: FSM, index/wait counters, code register, result flags.

## Test plan
- Reset release, then `start` with DEFAULT_CODE against the lock: `btn_out` = 100,001,010,001,100 in cycles 2..6; `done` in cycle 8 with `pass`=1, `fail`=0.
- `code_ld` with `code_in`=10'b10_00_01_01_10 (sequence 2,1,1,0,2), then `start`: `fail`=1 and `done` in cycle 8.
- `ld_in` forced to 00 throughout: `timeout`=1 and `done` in cycle 7+RESULT_WAIT=11; `btn_out`=0 during WAIT.
- `start` and `code_ld` pulsed while `busy`: no restart and no code change; the next frame still sends the prior code.
- `code_ld`+`start` in the same IDLE cycle with code of all SYM_NONE: `btn_out`=000 for 5 cycles, then `fail`=1.
- `reset` low in cycle 4: `btn_out`=0, `busy`=0 and `lock_rst`=1 immediately; after release the code equals DEFAULT_CODE and the flags are 0.

Source files
------------

// File: rtl/door_code_pkg.sv
// Shared types and constants for the door-lock code sender.
package door_code_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SEND,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SYM_0    = 2'b00;
  localparam logic [1:0] SYM_1    = 2'b01;
  localparam logic [1:0] SYM_2    = 2'b10;
  localparam logic [1:0] SYM_NONE = 2'b11;

  localparam logic [2:0] BTN_0    = 3'b001;
  localparam logic [2:0] BTN_1    = 3'b010;
  localparam logic [2:0] BTN_2    = 3'b100;
  localparam logic [2:0] BTN_NONE = 3'b000;

  // Decodes to the button sequence 2,0,1,0,2 (sym0 in the low bits).
  localparam logic [9:0] DEFAULT_CODE = 10'b10_00_01_00_10;

endpackage

// File: rtl/code_sym_decode.sv
// Maps a 2-bit code symbol to a one-hot button drive.
// Purely combinational; no flow control.
module code_sym_decode
  import door_code_pkg::*;
(
  input  logic [1:0] sym,
  output logic [2:0] btn
);

  always_comb begin
    btn = BTN_NONE;
    case (sym)
      SYM_0:   btn = BTN_0;
      SYM_1:   btn = BTN_1;
      SYM_2:   btn = BTN_2;
      default: btn = BTN_NONE;  // SYM_NONE sends no press, i.e. a wrong digit
    endcase
  end

endmodule

// File: rtl/door_code_sender.sv
// Resets the lock, plays the stored code one symbol per clock, then captures pass/fail/timeout.
// start-to-done is 8 cycles (7+RESULT_WAIT on timeout); start/code_ld are ignored while busy.
module door_code_sender #(
  parameter int                    N_SYM        = 5,
  parameter int                    RESULT_WAIT  = 4,
  parameter logic [2*N_SYM-1:0]    DEFAULT_CODE = door_code_pkg::DEFAULT_CODE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 code_ld,
  input  logic [2*N_SYM-1:0]   code_in,
  input  logic                 start,
  input  logic [1:0]           ld_in,
  output logic [2:0]           btn_out,
  output logic                 lock_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout
);

  import door_code_pkg::*;

  localparam int IW = $clog2(N_SYM);
  localparam int WW = $clog2(RESULT_WAIT + 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        nxt_idx;
  logic [WW-1:0]        wcnt;
  logic [2*N_SYM-1:0]   code_q;
  logic [1:0]           sel_sym;
  logic [2:0]           sel_btn;
  logic                 last_sym;

  // btn_out is registered, so the symbol picked here is the one shown next cycle.
  always_comb begin
    nxt_idx = (state == SEND) ? idx + 1'b1 : '0;
    sel_sym = SYM_NONE;
    for (int k = 0; k < N_SYM; k++) begin
      if (nxt_idx == IW'(k)) sel_sym = code_q[2*k +: 2];
    end
  end

  assign last_sym = (idx == IW'(N_SYM - 1));

  code_sym_decode u_dec (
    .sym (sel_sym),
    .btn (sel_btn)
  );

  // Lock stays in reset whenever this block is in reset.
  assign lock_rst = (state == RST) || !reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      wcnt    <= '0;
      code_q  <= DEFAULT_CODE;
      btn_out <= BTN_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (code_ld) code_q <= code_in;
          if (start) begin
            state   <= RST;
            busy    <= 1'b1;
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        RST: begin
          state   <= SEND;
          idx     <= '0;
          btn_out <= sel_btn;
        end
        SEND: begin
          if (last_sym) begin
            state   <= WAIT;
            wcnt    <= '0;
            btn_out <= BTN_NONE;
          end else begin
            idx     <= nxt_idx;
            btn_out <= sel_btn;
          end
        end
        WAIT: begin
          // 2'b11 is illegal from the lock and lands in the fail branch.
          if (ld_in == 2'b10) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (ld_in[0]) begin
            fail  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (wcnt == WW'(RESULT_WAIT - 1)) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_door_code_sender.sv
// Directed bench for door_code_sender with a behavioural 2,0,1,0,2 lock attached.
module tb_door_code_sender;

  localparam logic [9:0] DEF_CODE = 10'b10_00_01_00_10;
  localparam logic [9:0] C2       = 10'b10_00_01_01_10;
  localparam logic [9:0] ALL_NONE = 10'b11_11_11_11_11;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_ld;
  logic [9:0] code_in;
  logic       start;
  logic [1:0] ld_in;
  logic [2:0] btn_out;
  logic       lock_rst, busy, done, pass, fail, timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  door_code_sender #(.N_SYM(5), .RESULT_WAIT(4), .DEFAULT_CODE(DEF_CODE)) dut (
    .clk      (clk),
    .reset    (reset),
    .code_ld  (code_ld),
    .code_in  (code_in),
    .start    (start),
    .ld_in    (ld_in),
    .btn_out  (btn_out),
    .lock_rst (lock_rst),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout)
  );

  // Lock model: after its reset, samples 5 buttons and reports pass (10) or fail (01).
  logic [2:0] lock_seq [5] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b100};
  int         lk_cnt = 0;
  logic       lk_ok  = 1'b1;
  logic [1:0] lk_ld  = 2'b00;
  logic       lock_en = 1'b1;

  always @(posedge clk) begin
    if (lock_rst) begin
      lk_cnt <= 0;
      lk_ok  <= 1'b1;
      lk_ld  <= 2'b00;
    end else if (lk_cnt < 5) begin
      lk_cnt <= lk_cnt + 1;
      if (btn_out != lock_seq[lk_cnt]) lk_ok <= 1'b0;
      if (lk_cnt == 4) lk_ld <= (lk_ok && btn_out == lock_seq[4]) ? 2'b10 : 2'b01;
    end
  end

  assign ld_in = lock_en ? lk_ld : 2'b00;

  // {btn_out, busy, done, lock_rst, pass, fail, timeout}
  logic [8:0] obs;
  assign obs = {btn_out, busy, done, lock_rst, pass, fail, timeout};

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got btn/busy/done/lrst/p/f/t=%b want %b", name, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // One full frame checked every cycle; expectations derived from the cycle map.
  task automatic frame(input logic ld, input logic [9:0] cin, input logic [9:0] ecode,
                       input logic [2:0] pflags, input logic [2:0] eflags,
                       input int dcyc, input logic midpulse, input string tag);
    logic [2:0] b;
    logic [2:0] fl;
    for (int c = 0; c <= dcyc + 1; c++) begin
      @(negedge clk);
      start   = (c == 0) || (midpulse && c == 3);
      code_ld = (c == 0 && ld) || (midpulse && c == 3);
      code_in = cin;
      b = 3'b000;
      if (c >= 2 && c <= 6) b = onehot(ecode[2*(c-2) +: 2]);
      fl = (c == 0) ? pflags : (c >= dcyc) ? eflags : 3'b000;
      chk($sformatf("%s c%0d", tag, c), obs,
          {b, (c >= 1 && c <= dcyc), (c == dcyc), (c == 1), fl});
    end
    start   = 1'b0;
    code_ld = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       code_ld;
    logic [9:0] code_in;
    logic [8:0] exp;
  } vec_t;

  vec_t vt [21];

  initial begin
    vt[0]  = '{1'b1, 1'b0, 10'h0, 9'b000_0_0_0_000};
    vt[1]  = '{1'b0, 1'b0, 10'h0, 9'b000_1_0_1_000};
    vt[2]  = '{1'b0, 1'b0, 10'h0, 9'b100_1_0_0_000};
    vt[3]  = '{1'b0, 1'b0, 10'h0, 9'b001_1_0_0_000};
    vt[4]  = '{1'b0, 1'b0, 10'h0, 9'b010_1_0_0_000};
    vt[5]  = '{1'b0, 1'b0, 10'h0, 9'b001_1_0_0_000};
    vt[6]  = '{1'b0, 1'b0, 10'h0, 9'b100_1_0_0_000};
    vt[7]  = '{1'b0, 1'b0, 10'h0, 9'b000_1_0_0_000};
    vt[8]  = '{1'b0, 1'b0, 10'h0, 9'b000_1_1_0_100};
    vt[9]  = '{1'b0, 1'b0, 10'h0, 9'b000_0_0_0_100};
    vt[10] = '{1'b0, 1'b1, C2,    9'b000_0_0_0_100};
    vt[11] = '{1'b1, 1'b0, 10'h0, 9'b000_0_0_0_100};
    vt[12] = '{1'b0, 1'b0, 10'h0, 9'b000_1_0_1_000};
    vt[13] = '{1'b0, 1'b0, 10'h0, 9'b100_1_0_0_000};
    vt[14] = '{1'b0, 1'b0, 10'h0, 9'b010_1_0_0_000};
    vt[15] = '{1'b0, 1'b0, 10'h0, 9'b010_1_0_0_000};
    vt[16] = '{1'b0, 1'b0, 10'h0, 9'b001_1_0_0_000};
    vt[17] = '{1'b0, 1'b0, 10'h0, 9'b100_1_0_0_000};
    vt[18] = '{1'b0, 1'b0, 10'h0, 9'b000_1_0_0_000};
    vt[19] = '{1'b0, 1'b0, 10'h0, 9'b000_1_1_0_010};
    vt[20] = '{1'b0, 1'b0, 10'h0, 9'b000_0_0_0_010};

    reset   = 1'b0;
    start   = 1'b0;
    code_ld = 1'b0;
    code_in = '0;
    repeat (2) @(negedge clk);
    chk("in_reset", obs, 9'b000_0_0_1_000);
    reset = 1'b1;
    @(negedge clk);
    chk("after_release", obs, 9'b000_0_0_0_000);

    // Default-code pass frame, then load C2 and get a fail frame.
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      start   = vt[i].start;
      code_ld = vt[i].code_ld;
      code_in = vt[i].code_in;
      chk($sformatf("vec%0d", i), obs, vt[i].exp);
    end
    start   = 1'b0;
    code_ld = 1'b0;

    // Silent lock: timeout after RESULT_WAIT cycles of WAIT.
    lock_en = 1'b0;
    frame(1'b0, 10'h0, C2, 3'b010, 3'b001, 11, 1'b0, "timeout");
    lock_en = 1'b1;

    // start/code_ld while busy are ignored; next frame still sends C2.
    frame(1'b0, DEF_CODE, C2, 3'b001, 3'b010, 8, 1'b1, "busy_ign");
    frame(1'b0, DEF_CODE, C2, 3'b010, 3'b010, 8, 1'b0, "after_ign");

    // Load and start in the same cycle; the new all-SYM_NONE code is sent.
    frame(1'b1, ALL_NONE, ALL_NONE, 3'b010, 3'b010, 8, 1'b0, "ld_start");

    // Reset asserted in cycle 4 of a C2 frame.
    @(negedge clk);
    start = 1'b1; code_ld = 1'b1; code_in = C2;
    @(negedge clk);
    start = 1'b0; code_ld = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_mid_reset", obs, 9'b010_1_0_0_000);
    reset = 1'b0;
    #1;
    chk("mid_reset", obs, 9'b000_0_0_1_000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_release", obs, 9'b000_0_0_0_000);
    frame(1'b0, 10'h0, DEF_CODE, 3'b000, 3'b100, 8, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
